sram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port 32x16384 SRAM macro. It shares the macro between the instruction-fetch port (read-only) and the load/store port (read/write with byte enables). It drives the macro's active-low CSb/WEb/OEb strobes and its bidirectional DATA bus. Sub-word stores are performed as read-modify-write sequences because the macro has no byte mask.

---
 rtl/sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer sharing a single-port SRAM macro between fetch and load/store.
// Sub-word stores are performed as read-modify-write; grants and strobes are combinational.
module sram_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_req_i,
    input  logic [31:0]             instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [31:0]             data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    sram_csb_o,
    output logic                    sram_web_o,
    output logic                    sram_oeb_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr_o,
    inout  wire  [DATA_WIDTH-1:0]   sram_data_io
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    // The RMW read access is issued from IDLE in the grant cycle, so it needs no state of its own.
    typedef enum logic [1:0] {IDLE, RD_RESP, RMW_MRG, RMW_WR} state_t;

    state_t                  state_q, state_d;
    logic                    last_data_q;
    logic                    rd_data_q;
    logic                    wr_ack_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BE_W-1:0]         be_q;
    logic [DATA_WIDTH-1:0]   merge_q, merge_d;
    logic [DATA_WIDTH-1:0]   bus_out;
    logic                    instr_elig, data_elig, pick_data, pick_instr;
    logic                    st_full, st_none, st_part;
    logic [ADDR_WIDTH-1:0]   instr_waddr, data_waddr;
    logic                    unused_addr;

    assign instr_waddr = instr_addr_i[ADDR_WIDTH+1:2];
    assign data_waddr  = data_addr_i[ADDR_WIDTH+1:2];
    assign unused_addr = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0],
                           data_addr_i[31:ADDR_WIDTH+2], data_addr_i[1:0]};

    assign st_full = data_we_i && (data_be_i == {BE_W{1'b1}});
    assign st_none = data_we_i && (data_be_i == '0);
    assign st_part = data_we_i && !st_full && !st_none;

    // Stores are held off in RD_RESP because the macro owns the bus then.
    always_comb begin
        instr_elig = 1'b0;
        data_elig  = 1'b0;
        if (rst_n && (state_q == IDLE || state_q == RD_RESP)) begin
            instr_elig = instr_req_i;
            data_elig  = data_req_i && (state_q == IDLE || !data_we_i);
        end
        pick_data  = data_elig && (!instr_elig || !last_data_q);
        pick_instr = instr_elig && !pick_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RD_RESP: begin
                if (pick_instr || (pick_data && !data_we_i)) state_d = RD_RESP;
                else if (pick_data && st_part)              state_d = RMW_MRG;
                else                                         state_d = IDLE;
            end
            RMW_MRG: state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        merge_d = sram_data_io;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be_q[i]) merge_d[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data_q <= 1'b0;
            rd_data_q   <= 1'b0;
            wr_ack_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            merge_q     <= '0;
        end else begin
            if (pick_data || pick_instr) last_data_q <= pick_data;
            if (pick_instr || (pick_data && !data_we_i)) rd_data_q <= pick_data;
            wr_ack_q <= (pick_data && data_we_i && !st_part) || (state_q == RMW_WR);
            if (pick_data && data_we_i) begin
                addr_q  <= data_waddr;
                wdata_q <= data_wdata_i;
                be_q    <= data_be_i;
            end
            if (state_q == RMW_MRG) merge_q <= merge_d;
        end
    end

    always_comb begin
        instr_gnt_o    = pick_instr;
        data_gnt_o     = pick_data;
        instr_rvalid_o = (state_q == RD_RESP) && !rd_data_q;
        data_rvalid_o  = ((state_q == RD_RESP) && rd_data_q) || wr_ack_q;
        instr_rdata_o  = instr_rvalid_o ? sram_data_io : '0;
        data_rdata_o   = ((state_q == RD_RESP) && rd_data_q) ? sram_data_io : '0;
        sram_csb_o     = 1'b1;
        sram_web_o     = 1'b1;
        sram_oeb_o     = 1'b1;
        sram_addr_o    = addr_q;
        bus_out        = merge_q;
        if (state_q == RD_RESP || state_q == RMW_MRG) sram_oeb_o = 1'b0;
        if (pick_instr) begin
            sram_csb_o  = 1'b0;
            sram_addr_o = instr_waddr;
        end else if (pick_data) begin
            sram_addr_o = data_waddr;
            sram_csb_o  = st_none;
            if (st_full) begin
                sram_web_o = 1'b0;
                bus_out    = data_wdata_i;
            end
        end
        if (state_q == RMW_WR) begin
            sram_csb_o = 1'b0;
            sram_web_o = 1'b0;
        end
    end

    assign sram_data_io = sram_web_o ? {DATA_WIDTH{1'bz}} : bus_out;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural SRAM macro model.
`timescale 1ns/1ps
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        instr_gnt, instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_csb, sram_web, sram_oeb;
    logic [13:0] sram_addr;
    wire  [31:0] sram_data;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural macro: write at end of access cycle, read data driven next cycle while oeb=0.
    logic [31:0] mem [0:16383];
    logic [31:0] rd_q = '0;
    logic        rd_en = 1'b0;
    int          wr_count = 0;
    int          clash_count = 0;

    assign sram_data = (rd_en && !sram_oeb && sram_web) ? rd_q : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        rd_en <= !sram_csb && sram_web;
        if (!sram_csb && sram_web) rd_q <= mem[sram_addr];
        if (!sram_csb && !sram_web) begin
            mem[sram_addr] <= sram_data;
            wr_count <= wr_count + 1;
        end
    end

    always @(negedge clk) if (!sram_web && !sram_oeb) clash_count <= clash_count + 1;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata),
        .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .sram_csb_o(sram_csb), .sram_web_o(sram_web), .sram_oeb_o(sram_oeb),
        .sram_addr_o(sram_addr), .sram_data_io(sram_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle, landing 1ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        instr_req = 1'b0;
        data_req  = 1'b0;
        rst_n     = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    int wr_before;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[1]  = 32'hA1A1_A1A1;
        mem[2]  = 32'hD2D2_D2D2;
        mem[4]  = 32'hDEAD_BEEF;
        mem[8]  = 32'h1122_3344;
        mem[16] = 32'h0BAD_F00D;
        mem[20] = 32'hCAFE_F00D;

        // Reset state with a request asserted
        instr_req = 1'b1;
        instr_addr = 32'h10;
        #12;
        check("rst_instr_gnt", 32'(instr_gnt), 32'd0);
        check("rst_csb", 32'(sram_csb), 32'd1);
        check("rst_web", 32'(sram_web), 32'd1);
        check("rst_oeb", 32'(sram_oeb), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_rvalid", {30'd0, instr_rvalid, data_rvalid}, 32'd0);
        check("rst_rdata", instr_rdata | data_rdata, 32'd0);
        do_reset();

        // Both ports reading continuously: alternate, data first
        instr_req = 1'b1; instr_addr = 32'h4;
        data_req  = 1'b1; data_we = 1'b0; data_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("alt_data_gnt", 32'(data_gnt), 32'((i % 2) == 0));
            check("alt_instr_gnt", 32'(instr_gnt), 32'((i % 2) == 1));
            check("alt_data_rvalid", 32'(data_rvalid), 32'((i % 2) == 1));
            check("alt_instr_rvalid", 32'(instr_rvalid), 32'(i > 0 && (i % 2) == 0));
            if ((i % 2) == 1) check("alt_data_rdata", data_rdata, 32'hD2D2_D2D2);
            if (i > 0 && (i % 2) == 0) check("alt_instr_rdata", instr_rdata, 32'hA1A1_A1A1);
            cyc();
        end
        instr_req = 1'b0; data_req = 1'b0;
        settle();
        check("alt_last_instr_rvalid", 32'(instr_rvalid), 32'd1);
        check("alt_last_instr_rdata", instr_rdata, 32'hA1A1_A1A1);
        cyc();

        // Single fetch from 0x10
        instr_req = 1'b1; instr_addr = 32'h10;
        settle();
        check("fetch_gnt", 32'(instr_gnt), 32'd1);
        check("fetch_csb", 32'(sram_csb), 32'd0);
        check("fetch_web", 32'(sram_web), 32'd1);
        check("fetch_addr", 32'(sram_addr), 32'd4);
        cyc();
        instr_req = 1'b0;
        settle();
        check("fetch_rvalid", 32'(instr_rvalid), 32'd1);
        check("fetch_rdata", instr_rdata, 32'hDEAD_BEEF);
        cyc();

        // Partial store be=0010 with a fetch pending
        wr_before = wr_count;
        instr_req = 1'b1; instr_addr = 32'h10;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0010;
        data_addr = 32'h20; data_wdata = 32'h0000_AA00;
        settle();
        check("rmw_n_data_gnt", 32'(data_gnt), 32'd1);
        check("rmw_n_instr_gnt", 32'(instr_gnt), 32'd0);
        check("rmw_n_read", {30'd0, sram_csb, sram_web}, 32'd1);
        check("rmw_n_addr", 32'(sram_addr), 32'd8);
        cyc();
        data_req = 1'b0;
        settle();
        check("rmw_n1_instr_gnt", 32'(instr_gnt), 32'd0);
        check("rmw_n1_csb", 32'(sram_csb), 32'd1);
        check("rmw_n1_oeb", 32'(sram_oeb), 32'd0);
        cyc();
        settle();
        check("rmw_n2_instr_gnt", 32'(instr_gnt), 32'd0);
        check("rmw_n2_write", {30'd0, sram_csb, sram_web}, 32'd0);
        check("rmw_n2_addr", 32'(sram_addr), 32'd8);
        check("rmw_n2_bus", sram_data, 32'h1122_AA44);
        cyc();
        settle();
        check("rmw_n3_data_rvalid", 32'(data_rvalid), 32'd1);
        check("rmw_n3_instr_gnt", 32'(instr_gnt), 32'd1);
        cyc();
        instr_req = 1'b0;
        settle();
        check("rmw_fetch_rdata", instr_rdata, 32'hDEAD_BEEF);
        cyc();
        check("rmw_write_count", 32'(wr_count - wr_before), 32'd1);
        check("rmw_mem", mem[8], 32'h1122_AA44);

        // Load followed by a full store: store waits out RD_RESP
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8;
        settle();
        check("ls_load_gnt", 32'(data_gnt), 32'd1);
        cyc();
        data_we = 1'b1; data_be = 4'hF; data_addr = 32'h30; data_wdata = 32'h55AA_55AA;
        settle();
        check("ls_n1_store_gnt", 32'(data_gnt), 32'd0);
        check("ls_n1_rvalid", 32'(data_rvalid), 32'd1);
        check("ls_n1_rdata", data_rdata, 32'hD2D2_D2D2);
        cyc();
        settle();
        check("ls_n2_store_gnt", 32'(data_gnt), 32'd1);
        check("ls_n2_write", {30'd0, sram_csb, sram_web}, 32'd0);
        check("ls_n2_addr", 32'(sram_addr), 32'd12);
        cyc();
        data_req = 1'b0;
        settle();
        check("ls_n3_rvalid", 32'(data_rvalid), 32'd1);
        cyc();
        check("ls_mem", mem[12], 32'h55AA_55AA);

        // Store with no byte enables: no macro access
        wr_before = wr_count;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'h0;
        data_addr = 32'h40; data_wdata = 32'hFFFF_FFFF;
        settle();
        check("be0_gnt", 32'(data_gnt), 32'd1);
        check("be0_csb", 32'(sram_csb), 32'd1);
        cyc();
        data_req = 1'b0;
        settle();
        check("be0_rvalid", 32'(data_rvalid), 32'd1);
        cyc();
        check("be0_mem", mem[16], 32'h0BAD_F00D);
        check("be0_write_count", 32'(wr_count - wr_before), 32'd0);

        // Reset during RMW_MRG abandons the write
        wr_before = wr_count;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0001;
        data_addr = 32'h50; data_wdata = 32'h0000_00FF;
        settle();
        check("rstm_gnt", 32'(data_gnt), 32'd1);
        cyc();
        data_req = 1'b0;
        settle();
        check("rstm_in_merge_oeb", 32'(sram_oeb), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstm_strobes", {29'd0, sram_csb, sram_web, sram_oeb}, 32'd7);
        check("rstm_gnt_low", {30'd0, instr_gnt, data_gnt}, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        check("rstm_mem", mem[20], 32'hCAFE_F00D);
        check("rstm_write_count", 32'(wr_count - wr_before), 32'd0);

        check("no_web_oeb_overlap", 32'(clash_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
